pll_reconfig_ctrl: RTL and testbench

- Sequencer for a Gowin rPLL used with dynamic dividers (DYN_IDIV/FBDIV/ODIV_SEL = "true").
- Drives the PLL RESET and IDSEL/FBDSEL/ODSEL inputs, and supervises LOCK with a settle window, timeout and bounded retries.
- Produces a qualified clk_ok for downstream reset release, and accepts runtime frequency-change requests via a valid/ready handshake.
- Sits between board top-level and the rPLL wrapper, in the reference-clock domain.

---
 rtl/pll_reconfig_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - Gowin rPLL reset/divider sequencer with lock supervision
//
// Drives the rPLL RESET and dynamic IDSEL/FBDSEL/ODSEL inputs, qualifies LOCK
// with a settle window, a per-attempt timeout and bounded retries, and accepts
// runtime divider changes through a valid/ready handshake. Runs entirely in the
// reference-clock domain (the rPLL CLKIN clock).
//
// Ports:
//   clk           reference clock
//   rst           asynchronous active-high reset
//   cfg_valid     divider change request
//   cfg_ready     request accepted when cfg_valid && cfg_ready
//   cfg_idsel     raw IDSEL code (Gowin encoding)
//   cfg_fbdsel    raw FBDSEL code
//   cfg_odsel     raw ODSEL code
//   pll_lock      rPLL LOCK, asynchronous to clk
//   pll_reset     to rPLL RESET
//   pll_idsel     to rPLL IDSEL
//   pll_fbdsel    to rPLL FBDSEL
//   pll_odsel     to rPLL ODSEL
//   clk_ok        PLL output qualified for downstream reset release
//   cfg_error     retries exhausted (level, cleared by a new request)
//   busy          lock sequence in progress
//   lock_loss_cnt saturating count of lock losses in run state
//                 (present only when PLL_RECONFIG_CTRL_STATS_EN is defined)
//
// Build option: PLL_RECONFIG_CTRL_STATS_EN adds the lock_loss_cnt output.

module pll_reconfig_ctrl #(
    parameter logic [5:0] IDSEL_INIT         = 6'd0,
    parameter logic [5:0] FBDSEL_INIT        = 6'd0,
    parameter logic [5:0] ODSEL_INIT         = 6'd0,
    parameter int         RESET_CYCLES       = 16,
    parameter int         LOCK_STABLE_CYCLES = 1024,
    parameter int         LOCK_TIMEOUT       = 65536,
    parameter int         MAX_RETRIES        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    output logic       clk_ok,
    output logic       cfg_error,
    output logic       busy
`ifdef PLL_RECONFIG_CTRL_STATS_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam logic [2:0] S_RST    = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    // Each counter is wide enough for its terminal value; every state stops
    // counting at the terminal compare, so none of them can wrap.
    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RTY_W:0]   RTY_LIM  = (RTY_W + 1)'(MAX_RETRIES);

    logic [2:0]       state;
    logic [RST_W-1:0] rst_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [STB_W-1:0] stb_cnt;
    logic [RTY_W-1:0] retry_cnt;

    logic lock_meta;
    logic lock_s;

    logic           handshake;
    logic [RTY_W:0] retry_inc;
    logic           retry_exhausted;

    // Two-flop synchronizer for the asynchronous LOCK input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        handshake       = cfg_valid && cfg_ready;
        // One bit wider than retry_cnt so the compare never overflows, even
        // when a lock loss has already consumed a retry with MAX_RETRIES=1.
        retry_inc       = {1'b0, retry_cnt} + (RTY_W + 1)'(1);
        retry_exhausted = (retry_inc >= RTY_LIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RST;
            rst_cnt    <= '0;
            to_cnt     <= '0;
            stb_cnt    <= '0;
            retry_cnt  <= '0;
            pll_reset  <= 1'b1;
            pll_idsel  <= IDSEL_INIT;
            pll_fbdsel <= FBDSEL_INIT;
            pll_odsel  <= ODSEL_INIT;
            clk_ok     <= 1'b0;
            cfg_ready  <= 1'b0;
            cfg_error  <= 1'b0;
            busy       <= 1'b1;
        end else begin
            case (state)
                S_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        pll_reset <= 1'b0;
                        rst_cnt   <= '0;
                        to_cnt    <= '0;
                        state     <= S_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end

                S_WAIT: begin
                    if (lock_s) begin
                        // The cycle that saw lock already counts as the
                        // first stable cycle.
                        if (LOCK_STABLE_CYCLES == 1) begin
                            state     <= S_RUN;
                            clk_ok    <= 1'b1;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b0;
                            retry_cnt <= '0;
                            stb_cnt   <= '0;
                        end else begin
                            stb_cnt <= STB_W'(1);
                            state   <= S_STABLE;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        if (retry_exhausted) begin
                            // pll_reset is held high while parked in failure.
                            state     <= S_FAIL;
                            pll_reset <= 1'b1;
                            cfg_error <= 1'b1;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            retry_cnt <= retry_inc[RTY_W-1:0];
                            state     <= S_RST;
                            pll_reset <= 1'b1;
                            rst_cnt   <= '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_STABLE: begin
                    // Timeout counter is intentionally frozen here and resumes
                    // in S_WAIT, so lock chatter cannot extend an attempt forever.
                    if (!lock_s) begin
                        state <= S_WAIT;
                    end else if (stb_cnt == STB_LAST) begin
                        state     <= S_RUN;
                        clk_ok    <= 1'b1;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                        retry_cnt <= '0;
                        stb_cnt   <= '0;
                    end else begin
                        stb_cnt <= stb_cnt + STB_W'(1);
                    end
                end

                S_RUN: begin
                    // A request takes priority over a simultaneous lock loss:
                    // both restart the PLL, but only the request resets retries.
                    if (handshake) begin
                        pll_idsel  <= cfg_idsel;
                        pll_fbdsel <= cfg_fbdsel;
                        pll_odsel  <= cfg_odsel;
                        clk_ok     <= 1'b0;
                        cfg_ready  <= 1'b0;
                        busy       <= 1'b1;
                        retry_cnt  <= '0;
                        pll_reset  <= 1'b1;
                        rst_cnt    <= '0;
                        state      <= S_RST;
                    end else if (!lock_s) begin
                        clk_ok    <= 1'b0;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        retry_cnt <= retry_inc[RTY_W-1:0];
                        pll_reset <= 1'b1;
                        rst_cnt   <= '0;
                        state     <= S_RST;
                    end
                end

                S_FAIL: begin
                    if (handshake) begin
                        pll_idsel  <= cfg_idsel;
                        pll_fbdsel <= cfg_fbdsel;
                        pll_odsel  <= cfg_odsel;
                        cfg_error  <= 1'b0;
                        cfg_ready  <= 1'b0;
                        busy       <= 1'b1;
                        retry_cnt  <= '0;
                        rst_cnt    <= '0;
                        state      <= S_RST;
                    end
                end

                default: begin
                    state     <= S_RST;
                    rst_cnt   <= '0;
                    pll_reset <= 1'b1;
                    clk_ok    <= 1'b0;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

`ifdef PLL_RECONFIG_CTRL_STATS_EN
    logic lock_loss_evt;

    always_comb begin
        lock_loss_evt = (state == S_RUN) && !handshake && !lock_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt <= 8'd0;
        end else if (lock_loss_evt && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - scoreboard bench for pll_reconfig_ctrl

module tb_pll_reconfig_ctrl;

    localparam int RESET_CYCLES       = 4;
    localparam int LOCK_STABLE_CYCLES = 8;
    localparam int LOCK_TIMEOUT       = 32;
    localparam int MAX_RETRIES        = 2;
    // 2 sync flops + 1 cycle for S_WAIT to see lock + 7 further stable cycles
    localparam int RELOCK_LAT         = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idsel;
    logic [5:0] cfg_fbdsel;
    logic [5:0] cfg_odsel;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel;
    logic [5:0] pll_fbdsel;
    logic [5:0] pll_odsel;
    logic       clk_ok;
    logic       cfg_error;
    logic       busy;
`ifdef PLL_RECONFIG_CTRL_STATS_EN
    logic [7:0] lock_loss_cnt;
`endif

    always #5 clk = ~clk;

    pll_reconfig_ctrl #(
        .IDSEL_INIT        (6'd0),
        .FBDSEL_INIT       (6'd0),
        .ODSEL_INIT        (6'd0),
        .RESET_CYCLES      (RESET_CYCLES),
        .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
        .LOCK_TIMEOUT      (LOCK_TIMEOUT),
        .MAX_RETRIES       (MAX_RETRIES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_idsel    (cfg_idsel),
        .cfg_fbdsel   (cfg_fbdsel),
        .cfg_odsel    (cfg_odsel),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .pll_idsel    (pll_idsel),
        .pll_fbdsel   (pll_fbdsel),
        .pll_odsel    (pll_odsel),
        .clk_ok       (clk_ok),
        .cfg_error    (cfg_error),
        .busy         (busy)
`ifdef PLL_RECONFIG_CTRL_STATS_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } codes_t;

    codes_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle request and records the codes the DUT must apply.
    task automatic send_cfg(input logic [5:0] i, input logic [5:0] f, input logic [5:0] o);
        codes_t c;
        checks++;
        if (cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_cfg_ready got=%b exp=1", cfg_ready);
        end
        c.idsel = i; c.fbdsel = f; c.odsel = o;
        sb.push_back(c);
        cfg_valid  = 1'b1;
        cfg_idsel  = i;
        cfg_fbdsel = f;
        cfg_odsel  = o;
        tick();
        cfg_valid  = 1'b0;
    endtask

    // Follows one pll_reset pulse after an accepted request: codes must match
    // the scoreboard head throughout, and the pulse must last RESET_CYCLES.
    task automatic check_pulse(input string name);
        int n = 0;
        codes_t exp_c;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_sb_empty got=0 exp=1", name);
            return;
        end
        exp_c = sb.pop_front();
        while (pll_reset === 1'b1 && n < 64) begin
            checks++;
            if ({pll_idsel, pll_fbdsel, pll_odsel} !== exp_c) begin
                failures++;
                $display("FAIL %s_codes got=%h exp=%h", name,
                         {pll_idsel, pll_fbdsel, pll_odsel}, exp_c);
            end
            n++;
            tick();
        end
        checks++;
        if (n != RESET_CYCLES) begin
            failures++;
            $display("FAIL %s_pulse_len got=%0d exp=%0d", name, n, RESET_CYCLES);
        end
    endtask

    task automatic wait_reset_fall(input string name);
        int n = 0;
        while (pll_reset === 1'b1 && n < 64) begin
            n++;
            tick();
        end
        checks++;
        if (pll_reset !== 1'b0) begin
            failures++;
            $display("FAIL %s_reset_fall got=%b exp=0", name, pll_reset);
        end
    endtask

    // Raises lock while the DUT waits for it and times clk_ok.
    task automatic relock(input string name);
        int n = 0;
        pll_lock = 1'b1;
        while (clk_ok !== 1'b1 && n < 64) begin
            n++;
            tick();
        end
        checks++;
        if (n != RELOCK_LAT) begin
            failures++;
            $display("FAIL %s_relock_lat got=%0d exp=%0d", name, n, RELOCK_LAT);
        end
        checks++;
        if ({cfg_ready, busy, pll_reset, cfg_error} !== 4'b1000) begin
            failures++;
            $display("FAIL %s_run_flags got=%b exp=1000", name,
                     {cfg_ready, busy, pll_reset, cfg_error});
        end
    endtask

    task automatic test_reset();
        int n = 0;
        rst = 1'b1; cfg_valid = 1'b0; pll_lock = 1'b0;
        cfg_idsel = 6'd0; cfg_fbdsel = 6'd0; cfg_odsel = 6'd0;
        tick();
        tick();
        checks++;
        if ({pll_reset, clk_ok, cfg_ready, cfg_error, busy} !== 5'b10001) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=10001",
                     {pll_reset, clk_ok, cfg_ready, cfg_error, busy});
        end
        checks++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== 18'd0) begin
            failures++;
            $display("FAIL reset_codes got=%h exp=0", {pll_idsel, pll_fbdsel, pll_odsel});
        end
        rst = 1'b0;
        while (pll_reset === 1'b1 && n < 64) begin
            n++;
            tick();
        end
        checks++;
        if (n != RESET_CYCLES) begin
            failures++;
            $display("FAIL reset_pulse_len got=%0d exp=%0d", n, RESET_CYCLES);
        end
        checks++;
        if ({busy, clk_ok, cfg_ready} !== 3'b100) begin
            failures++;
            $display("FAIL reset_wait_flags got=%b exp=100", {busy, clk_ok, cfg_ready});
        end
        relock("init");
    endtask

    task automatic test_reconfig();
        pll_lock = 1'b0;
        send_cfg(6'd3, 6'd4, 6'd8);
        checks++;
        if ({clk_ok, cfg_ready, busy, pll_reset} !== 4'b0011) begin
            failures++;
            $display("FAIL reconfig_accept got=%b exp=0011", {clk_ok, cfg_ready, busy, pll_reset});
        end
        // A request held during the sequence must be ignored.
        cfg_valid = 1'b1;
        cfg_idsel = 6'h3F; cfg_fbdsel = 6'h3F; cfg_odsel = 6'h3F;
        check_pulse("reconfig");
        cfg_valid = 1'b0;
        relock("reconfig");
        checks++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'd3, 6'd4, 6'd8}) begin
            failures++;
            $display("FAIL reconfig_hold got=%h exp=%h",
                     {pll_idsel, pll_fbdsel, pll_odsel}, {6'd3, 6'd4, 6'd8});
        end
    endtask

    task automatic test_timeout_fail();
        int n;
        rst = 1'b1;
        pll_lock = 1'b0;
        tick();
        rst = 1'b0;
        for (int a = 0; a < MAX_RETRIES; a++) begin
            wait_reset_fall("timeout");
            n = 0;
            while (pll_reset === 1'b0 && n < 200) begin
                n++;
                tick();
            end
            checks++;
            if (n != LOCK_TIMEOUT) begin
                failures++;
                $display("FAIL timeout_len%0d got=%0d exp=%0d", a, n, LOCK_TIMEOUT);
            end
        end
        tick();
        tick();
        checks++;
        if ({cfg_error, pll_reset, cfg_ready, busy, clk_ok} !== 5'b11100) begin
            failures++;
            $display("FAIL fail_flags got=%b exp=11100",
                     {cfg_error, pll_reset, cfg_ready, busy, clk_ok});
        end
        send_cfg(6'd5, 6'd6, 6'd7);
        checks++;
        if ({cfg_error, busy, pll_reset, cfg_ready} !== 4'b0110) begin
            failures++;
            $display("FAIL fail_recover got=%b exp=0110", {cfg_error, busy, pll_reset, cfg_ready});
        end
        check_pulse("fail_recover");
        relock("fail_recover");
    endtask

    task automatic test_lock_glitch();
        pll_lock = 1'b0;
        send_cfg(6'd12, 6'd13, 6'd14);
        check_pulse("glitch");
        pll_lock = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        pll_lock = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (clk_ok !== 1'b0) begin
                failures++;
                $display("FAIL glitch_clk_ok%0d got=%b exp=0", k, clk_ok);
            end
        end
        relock("glitch");
    endtask

    task automatic test_lock_loss();
        int n = 0;
        pll_lock = 1'b0;
        while (clk_ok === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL loss_latency got=%0d exp=3", n);
        end
        checks++;
        if ({pll_reset, busy, cfg_ready} !== 3'b110) begin
            failures++;
            $display("FAIL loss_flags got=%b exp=110", {pll_reset, busy, cfg_ready});
        end
`ifdef PLL_RECONFIG_CTRL_STATS_EN
        checks++;
        if (lock_loss_cnt !== 8'd1) begin
            failures++;
            $display("FAIL loss_cnt1 got=%0d exp=1", lock_loss_cnt);
        end
`endif
        // The lock loss consumed one retry, so a single timeout now fails.
        wait_reset_fall("loss");
        n = 0;
        while (cfg_error !== 1'b1 && n < 200) begin
            n++;
            tick();
        end
        checks++;
        if (n != LOCK_TIMEOUT) begin
            failures++;
            $display("FAIL loss_to_fail got=%0d exp=%0d", n, LOCK_TIMEOUT);
        end
        checks++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'd12, 6'd13, 6'd14}) begin
            failures++;
            $display("FAIL loss_codes got=%h exp=%h",
                     {pll_idsel, pll_fbdsel, pll_odsel}, {6'd12, 6'd13, 6'd14});
        end
        send_cfg(6'd1, 6'd2, 6'd3);
        check_pulse("loss_recover");
        relock("loss_recover");
`ifdef PLL_RECONFIG_CTRL_STATS_EN
        for (int r = 0; r < 300; r++) begin
            pll_lock = 1'b0;
            n = 0;
            while (clk_ok === 1'b1 && n < 20) begin
                n++;
                tick();
            end
            wait_reset_fall("sat");
            relock("sat");
        end
        checks++;
        if (lock_loss_cnt !== 8'd255) begin
            failures++;
            $display("FAIL loss_cnt_sat got=%0d exp=255", lock_loss_cnt);
        end
`endif
    endtask

    task automatic test_rst_mid();
        pll_lock = 1'b0;
        send_cfg(6'd9, 6'd10, 6'd11);
        check_pulse("rst_mid");
        pll_lock = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if ({busy, clk_ok} !== 2'b10) begin
            failures++;
            $display("FAIL rst_mid_stable got=%b exp=10", {busy, clk_ok});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({pll_reset, clk_ok, cfg_ready, cfg_error, busy} !== 5'b10001) begin
            failures++;
            $display("FAIL rst_mid_flags got=%b exp=10001",
                     {pll_reset, clk_ok, cfg_ready, cfg_error, busy});
        end
        checks++;
        if ({pll_idsel, pll_fbdsel, pll_odsel} !== 18'd0) begin
            failures++;
            $display("FAIL rst_mid_codes got=%h exp=0", {pll_idsel, pll_fbdsel, pll_odsel});
        end
`ifdef PLL_RECONFIG_CTRL_STATS_EN
        checks++;
        if (lock_loss_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rst_mid_cnt got=%0d exp=0", lock_loss_cnt);
        end
`endif
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_reconfig();
        test_timeout_fail();
        test_lock_glitch();
        test_lock_loss();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
